fdiv_issue_queue: RTL

- Front-end stage directly upstream of the multi-cycle fdiv unit.
- Buffers divide requests from the pipeline in a small FIFO and issues them one at a time over fdiv's en/done/busy handshake.
- Holds each result in an output register with its tag until the consumer accepts it.
- Decouples the valid/ready core pipeline from the fdiv's non-pipelined, variable-latency interface.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fdiv_req_fifo.sv | 56 +++++
 rtl/fdiv_issue_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU front-end types: float32 alias, canonical quiet NaN, divide issue FSM states.
package fpu_pkg;

    typedef logic [31:0] float32_t;

    localparam float32_t FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } issue_state_t;

endpackage

// File: rtl/fdiv_req_fifo.sv
// Request FIFO for the fdiv issue queue: DEPTH entries of WIDTH bits, head visible combinationally.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module fdiv_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 69
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PtrW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fdiv_issue_queue.sv
// Issue queue in front of the multi-cycle fdiv unit: buffers requests, issues one at a time over
// en/done/busy, and holds each result with its tag until the consumer accepts it.
// Optional macro FDIV_ISSUE_TIMEOUT_EN adds a done-timeout that substitutes a quiet NaN result.
module fdiv_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAGW    = 5,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_x1,
    input  logic [31:0]     req_x2,
    input  logic [TAGW-1:0] req_tag,
    output logic            div_en,
    output logic [31:0]     div_x1,
    output logic [31:0]     div_x2,
    input  logic [31:0]     div_y,
    input  logic            div_done,
    input  logic            div_busy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_y,
    output logic [TAGW-1:0] rsp_tag,
    output logic            err_timeout
);

    localparam int unsigned EW = 64 + TAGW;

    issue_state_t    state_q, state_d;
    float32_t        op_x1_q, op_x1_d, op_x2_q, op_x2_d;
    logic [TAGW-1:0] tag_q, tag_d;
    float32_t        rsp_y_q, rsp_y_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;

    logic [EW-1:0]   fifo_head;
    logic            fifo_full, fifo_empty;
    logic            issue, timeout_hit;
    float32_t        head_x1, head_x2;
    logic [TAGW-1:0] head_tag;

    assign head_x1  = fifo_head[EW-1 -: 32];
    assign head_x2  = fifo_head[EW-33 -: 32];
    assign head_tag = fifo_head[TAGW-1:0];

    fdiv_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .push_i  (req_valid),
        .data_i  ({req_x1, req_x2, req_tag}),
        .pop_i   (issue),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Readiness comes from registered pointers only, so a full FIFO never pushes and pops at once.
    assign req_ready = !fifo_full;
    assign issue     = (state_q == IDLE) && !fifo_empty && !div_busy && !rsp_valid;
    assign div_en    = issue;
    // Head operands on the issue cycle, latched copies while the divide runs.
    assign div_x1    = issue ? head_x1 : op_x1_q;
    assign div_x2    = issue ? head_x2 : op_x2_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_y     = rsp_y_q;
    assign rsp_tag   = rsp_tag_q;

`ifdef FDIV_ISSUE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // The div_en cycle counts as elapsed cycle 0, so WAIT starts at 1 and the flag rises
    // exactly TIMEOUT cycles after div_en.
    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = (state_q == WAIT) && !div_done && (cnt_q == CntW'(TIMEOUT - 1));
        if (issue)                cnt_d = CntW'(1);
        else if (state_q == WAIT) cnt_d = cnt_q + CntW'(1);
        err_d = err_q | timeout_hit;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Issue FSM next state plus operand, tag and response register updates.
    always_comb begin
        state_d   = state_q;
        op_x1_d   = op_x1_q;
        op_x2_d   = op_x2_q;
        tag_d     = tag_q;
        rsp_y_d   = rsp_y_q;
        rsp_tag_d = rsp_tag_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    op_x1_d = head_x1;
                    op_x2_d = head_x2;
                    tag_d   = head_tag;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (div_done) begin
                    rsp_y_d   = div_y;
                    rsp_tag_d = tag_q;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    rsp_y_d   = FP_QNAN;
                    rsp_tag_d = tag_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight divide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            op_x1_q   <= '0;
            op_x2_q   <= '0;
            tag_q     <= '0;
            rsp_y_q   <= '0;
            rsp_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            op_x1_q   <= op_x1_d;
            op_x2_q   <= op_x2_d;
            tag_q     <= tag_d;
            rsp_y_q   <= rsp_y_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

endmodule
